cv32e40p_x_mem_responder: RTL and testbench



---
 rtl/cv32e40p_x_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_cv32e40p_x_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_mem_responder.sv
// rtl/cv32e40p_x_mem_responder.sv - XIF memory request responder driving an OBI data bus
//
// Accepts one coprocessor load/store at a time, rejects misaligned or reserved-size
// requests in the handshake cycle, issues a single OBI transaction and returns a
// one-cycle result pulse carrying the zero-extended load data or the bus error.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   x_mem_*                 coprocessor request handshake and exception response
//   x_mem_result_*          one-cycle completion pulse with id, rdata, err
//   data_*                  OBI initiator (req/gnt, addr/we/be/wdata, rvalid/rdata/err)
//
// Optional feature: define X_MEM_IO_PROTECT_EN to reject speculative accesses that
// fall in [IO_BASE, IO_BASE+IO_SIZE) with exccode 5 (load) / 7 (store).

module cv32e40p_x_mem_responder #(
    parameter int          ID_WIDTH  = 4,
    parameter logic [31:0] DATA_BASE = 32'h0000_0000,
    parameter logic [31:0] IO_BASE   = 32'h1A10_0000,
    parameter logic [31:0] IO_SIZE   = 32'h0010_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                x_mem_valid_i,
    output logic                x_mem_ready_o,
    input  logic [ID_WIDTH-1:0] x_mem_req_id_i,
    input  logic [31:0]         x_mem_req_addr_i,
    input  logic                x_mem_req_we_i,
    input  logic [1:0]          x_mem_req_size_i,
    input  logic [31:0]         x_mem_req_wdata_i,
    input  logic                x_mem_req_spec_i,
    output logic                x_mem_resp_exc_o,
    output logic [5:0]          x_mem_resp_exccode_o,
    output logic                x_mem_result_valid_o,
    output logic [ID_WIDTH-1:0] x_mem_result_id_o,
    output logic [31:0]         x_mem_result_rdata_o,
    output logic                x_mem_result_err_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                misaligned;
    logic                io_fault;
    logic                req_fault;
    logic [5:0]          fault_code;
    logic                handshake;
    logic [3:0]          req_be;
    logic [31:0]         req_wdata;
    logic [31:0]         rdata_shifted;
    logic [31:0]         rdata_aligned;

`ifdef X_MEM_IO_PROTECT_EN
    logic [31:0] io_offset;
    logic        unused_data_base;
    assign unused_data_base = ^DATA_BASE;
    // Subtract-then-compare keeps the range check correct even if the region wraps.
    assign io_offset = x_mem_req_addr_i - IO_BASE;
    assign io_fault  = x_mem_req_spec_i && (io_offset < IO_SIZE);
`else
    logic unused_io_cfg;
    assign unused_io_cfg = ^{DATA_BASE, IO_BASE, IO_SIZE, x_mem_req_spec_i};
    assign io_fault      = 1'b0;
`endif

    // Request classification and lane steering for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        req_be     = 4'b1111;
        req_wdata  = x_mem_req_wdata_i;
        case (x_mem_req_size_i)
            2'd0: begin
                req_be    = 4'b0001 << x_mem_req_addr_i[1:0];
                req_wdata = {4{x_mem_req_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = x_mem_req_addr_i[0];
                req_be     = 4'b0011 << x_mem_req_addr_i[1:0];
                req_wdata  = {2{x_mem_req_wdata_i[15:0]}};
            end
            2'd2: misaligned = |x_mem_req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase

        // Alignment faults outrank the I/O region fault.
        req_fault  = misaligned || io_fault;
        fault_code = 6'd0;
        if (misaligned) begin
            fault_code = x_mem_req_we_i ? 6'd6 : 6'd4;
        end else if (io_fault) begin
            fault_code = x_mem_req_we_i ? 6'd7 : 6'd5;
        end
    end

    // Bring the addressed lane(s) down to bit 0 and zero-extend to the access size.
    always_comb begin
        rdata_shifted = data_rdata_i >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    rdata_aligned = {24'd0, rdata_shifted[7:0]};
            2'd1:    rdata_aligned = {16'd0, rdata_shifted[15:0]};
            default: rdata_aligned = rdata_shifted;
        endcase
    end

    assign handshake = x_mem_valid_i && x_mem_ready_o;

    // State register and request/response holding registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            be_q    <= 4'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake && !req_fault) begin
                    state_d = ST_REQ;
                    id_d    = x_mem_req_id_i;
                    addr_d  = x_mem_req_addr_i;
                    we_d    = x_mem_req_we_i;
                    size_d  = x_mem_req_size_i;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                end
            end
            ST_REQ: begin
                if (data_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_rvalid_i) begin
                    state_d = ST_RESULT;
                    err_d   = data_err_i;
                    // Stores and errored loads report zero data.
                    rdata_d = (data_err_i || we_q) ? 32'd0 : rdata_aligned;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. Ready is masked while reset is held so every output reads 0 in reset.
    always_comb begin
        x_mem_ready_o        = (state_q == ST_IDLE) && !rst_i;
        x_mem_resp_exc_o     = handshake && req_fault;
        x_mem_resp_exccode_o = x_mem_resp_exc_o ? fault_code : 6'd0;
        x_mem_result_valid_o = (state_q == ST_RESULT);
        x_mem_result_id_o    = id_q;
        x_mem_result_rdata_o = rdata_q;
        x_mem_result_err_o   = err_q;
        data_req_o           = (state_q == ST_REQ);
        data_addr_o          = {addr_q[31:2], 2'b00};
        data_we_o            = we_q;
        data_be_o            = be_q;
        data_wdata_o         = wdata_q;
    end

endmodule

// File: tb/tb_cv32e40p_x_mem_responder.sv
// tb/tb_cv32e40p_x_mem_responder.sv - self-checking bench for cv32e40p_x_mem_responder

module tb_cv32e40p_x_mem_responder;

    localparam logic [31:0] TB_IO_BASE = 32'h1A10_0000;
    localparam logic [31:0] TB_IO_SIZE = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        x_mem_valid_i;
    logic        x_mem_ready_o;
    logic [3:0]  x_mem_req_id_i;
    logic [31:0] x_mem_req_addr_i;
    logic        x_mem_req_we_i;
    logic [1:0]  x_mem_req_size_i;
    logic [31:0] x_mem_req_wdata_i;
    logic        x_mem_req_spec_i;
    logic        x_mem_resp_exc_o;
    logic [5:0]  x_mem_resp_exccode_o;
    logic        x_mem_result_valid_o;
    logic [3:0]  x_mem_result_id_o;
    logic [31:0] x_mem_result_rdata_o;
    logic        x_mem_result_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cv32e40p_x_mem_responder #(.ID_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
        .x_mem_req_id_i(x_mem_req_id_i), .x_mem_req_addr_i(x_mem_req_addr_i),
        .x_mem_req_we_i(x_mem_req_we_i), .x_mem_req_size_i(x_mem_req_size_i),
        .x_mem_req_wdata_i(x_mem_req_wdata_i), .x_mem_req_spec_i(x_mem_req_spec_i),
        .x_mem_resp_exc_o(x_mem_resp_exc_o), .x_mem_resp_exccode_o(x_mem_resp_exccode_o),
        .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
        .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: access width in bytes drives every rule.
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic [5:0] m_exc(input logic [31:0] a, input logic we,
                                         input logic [1:0] s, input logic sp);
        if (s == 2'd3 || (a % nbytes(s)) != 0) return we ? 6'd6 : 6'd4;
`ifdef X_MEM_IO_PROTECT_EN
        if (sp && a >= TB_IO_BASE && a < TB_IO_BASE + TB_IO_SIZE) return we ? 6'd7 : 6'd5;
`endif
        if (sp) return 6'd0;
        return 6'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
        int mask = (1 << nbytes(s)) - 1;
        return 4'((mask << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic we,
                                            input logic [1:0] s, input logic [31:0] r,
                                            input logic e);
        logic [63:0] v;
        if (we || e) return 32'd0;
        v = (64'(r) >> (8 * (a % 4))) & ((64'd1 << (8 * nbytes(s))) - 64'd1);
        return v[31:0];
    endfunction

    // One request: handshake, gd grant wait cycles, immediate rvalid, result pulse.
    task automatic txn(input logic [3:0] id, input logic [31:0] a, input logic we,
                       input logic [1:0] s, input logic [31:0] w, input logic sp,
                       input int gd, input logic [31:0] r, input logic e);
        logic [5:0] exp_code;
        exp_code          = m_exc(a, we, s, sp);
        x_mem_valid_i     = 1'b1;
        x_mem_req_id_i    = id;
        x_mem_req_addr_i  = a;
        x_mem_req_we_i    = we;
        x_mem_req_size_i  = s;
        x_mem_req_wdata_i = w;
        x_mem_req_spec_i  = sp;
        #1;
        chk("hs_ready", 32'(x_mem_ready_o), 32'd1);
        chk("hs_exc", 32'(x_mem_resp_exc_o), 32'(exp_code != 0));
        chk("hs_exccode", 32'(x_mem_resp_exccode_o), 32'(exp_code));
        @(posedge clk); #1;
        x_mem_valid_i = 1'b0;
        if (exp_code != 0) begin
            chk("rej_req", 32'(data_req_o), 32'd0);
            chk("rej_ready", 32'(x_mem_ready_o), 32'd1);
            @(posedge clk); #1;
            chk("rej_result", 32'(x_mem_result_valid_o), 32'd0);
            chk("rej_req2", 32'(data_req_o), 32'd0);
            return;
        end
        for (int c = 0; c <= gd; c++) begin
            chk("req", 32'(data_req_o), 32'd1);
            chk("addr", data_addr_o, {a[31:2], 2'b00});
            chk("we", 32'(data_we_o), 32'(we));
            chk("be", 32'(data_be_o), 32'(m_be(a, s)));
            if (we) chk("wdata", data_wdata_o, m_wdata(w, s));
            chk("busy_ready", 32'(x_mem_ready_o), 32'd0);
            chk("early_result", 32'(x_mem_result_valid_o), 32'd0);
            if (c == gd) data_gnt_i = 1'b1;
            @(posedge clk); #1;
        end
        data_gnt_i    = 1'b0;
        chk("wait_req", 32'(data_req_o), 32'd0);
        chk("wait_ready", 32'(x_mem_ready_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = r;
        data_err_i    = e;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = $urandom;
        chk("res_valid", 32'(x_mem_result_valid_o), 32'd1);
        chk("res_id", 32'(x_mem_result_id_o), 32'(id));
        chk("res_rdata", x_mem_result_rdata_o, m_rdata(a, we, s, r, e));
        chk("res_err", 32'(x_mem_result_err_o), 32'(e));
        chk("res_ready", 32'(x_mem_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("post_valid", 32'(x_mem_result_valid_o), 32'd0);
        chk("post_ready", 32'(x_mem_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        rst_i = 1'b1;
        x_mem_valid_i = 1'b0; x_mem_req_id_i = '0; x_mem_req_addr_i = '0;
        x_mem_req_we_i = 1'b0; x_mem_req_size_i = 2'd0; x_mem_req_wdata_i = '0;
        x_mem_req_spec_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        data_rdata_i = '0; data_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(x_mem_ready_o), 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_result", 32'(x_mem_result_valid_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_rdata", x_mem_result_rdata_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(x_mem_ready_o), 32'd1);

        // Directed cases
        txn(4'd3, 32'h100, 1'b0, 2'd2, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        txn(4'd5, 32'h203, 1'b1, 2'd0, 32'hA5, 1'b0, 0, 32'h0, 1'b0);
        txn(4'd7, 32'h102, 1'b0, 2'd1, 32'h0, 1'b0, 0, 32'h1234ABCD, 1'b0);
        txn(4'd1, 32'h101, 1'b1, 2'd2, 32'h11223344, 1'b0, 0, 32'h0, 1'b0);
        txn(4'd9, 32'h300, 1'b0, 2'd3, 32'h0, 1'b0, 0, 32'h0, 1'b0);
        txn(4'd2, 32'h400, 1'b0, 2'd2, 32'h0, 1'b0, 5, 32'hCAFEF00D, 1'b1);
        txn(4'd4, 32'h1A100000, 1'b0, 2'd2, 32'h0, 1'b1, 0, 32'h87654321, 1'b0);

        // Stray gnt/rvalid in IDLE must be ignored
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        chk("stray_req", 32'(data_req_o), 32'd0);
        chk("stray_result", 32'(x_mem_result_valid_o), 32'd0);
        chk("stray_ready", 32'(x_mem_ready_o), 32'd1);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rs = 2'($urandom_range(0, 3));
            if (rs != 2'd3 && $urandom_range(0, 3) != 0) ra = ra & ~32'(nbytes(rs) - 1);
            txn(4'($urandom), ra, 1'($urandom), rs, $urandom, 1'($urandom),
                $urandom_range(0, 3), $urandom, ($urandom_range(0, 4) == 0));
        end

        // Reset while waiting for rvalid
        x_mem_valid_i = 1'b1; x_mem_req_addr_i = 32'h500; x_mem_req_we_i = 1'b0;
        x_mem_req_size_i = 2'd2; x_mem_req_spec_i = 1'b0; x_mem_req_id_i = 4'd6;
        @(posedge clk); #1;
        x_mem_valid_i = 1'b0; data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0;
        chk("pre_rst_req", 32'(data_req_o), 32'd0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_req", 32'(data_req_o), 32'd0);
        chk("mid_rst_result", 32'(x_mem_result_valid_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        chk("post_rst_ready", 32'(x_mem_ready_o), 32'd1);
        chk("post_rst_req", 32'(data_req_o), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_result", 32'(x_mem_result_valid_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
